alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Key-driven initiator for the 4-bit mini ALU. It collects operand A, operand B and the 2-bit opcode from the board keys in three debounced entry steps. It then issues them to an ALU responder over a req/ack handshake, captures result and flags, and shows them on the LEDs. The block sits in `hackathon_top` between the key/LED pins and the ALU.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a control key changes level (≥1).
- `ACK_TIMEOUT`, 255: number of cycles in ISSUE without ack before the error exit is taken; 0 disables the timeout.
- `clock`  in  1  sole clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high; all registers to reset values immediately.
- `key`  in  8  [3:0] data nibble, [4] enter, [5] clear, [6] chain, [7] ignored.
- `alu_a`  out  4  operand A presented to the ALU.
- `alu_b`  out  4  operand B presented to the ALU.
- `alu_op`  out  2  ALU opcode: 00 add, 01 sub, 10 and, 11 xor.
- `alu_req`  out  1  request, registered.
- `alu_ack`  in  1  responder ack; result is valid in the same cycle.
- `alu_result`  in  4  ALU result.
- `alu_carry`  in  1  carry/borrow flag.
- `alu_zero`  in  1  zero flag.
- `led`  out  8  status/result display, combinational from registers.

## Operation
- Input conditioning:
  - Every `key` bit passes a 2-flop synchronizer.
  - enter, clear and chain are each debounced: a per-key counter runs while the synchronized level ≠ the debounced level and resets otherwise. The debounced level flips when the counter reaches `DEBOUNCE_CYCLES`.
  - A rising debounced level yields a one-cycle pulse.
  - The data nibble is synchronized only, not debounced, and is sampled on the enter pulse.
- FSM states: GET_A (reset state), GET_B, GET_OP, ISSUE, SHOW.
  - GET_A: enter → A=data, go to GET_B. chain with result_valid=1 → A=last result, go to GET_B.
  - GET_B: enter → B=data, go to GET_OP.
  - GET_OP: enter → op=data[1:0], go to ISSUE.
  - ISSUE: `alu_req`=1. `alu_a/b/op` are held constant until exit.
    - First edge with ack=1: capture result/carry/zero, set result_valid=1, error=0, go to SHOW.
    - Timeout, counted from ISSUE entry: error=1, result/carry/zero=0, result_valid=0, go to SHOW.
  - SHOW: enter → GET_A. chain with result_valid=1 → A=result, go to GET_B. chain with error=1 is ignored.
- Clear pulse, from any state: go to GET_A. A, B, op, result, flags, error and result_valid all go to 0.
- Pulse priority within one cycle: clear > enter > chain.
- `alu_ack` is ignored outside ISSUE, including a late ack after a clear or a timeout.
- LED mapping:
  - GET_A/GET_B/GET_OP: led[3:0]=synchronized data; led[6:4]=001/010/100 respectively; led[7]=0.
  - ISSUE: led=8'h80.
  - SHOW: led[3:0]=result, [4]=carry, [5]=zero, [6]=error, [7]=1.
- Reset values: state GET_A, all registers 0, `alu_req`=0, `alu_a/b/op`=0, `led`=8'h10.

## Timing
- Control key change → pulse: the debounced level flips on edge DEBOUNCE_CYCLES+2 after the raw change. The pulse is high for exactly the following cycle, and the FSM acts on edge DEBOUNCE_CYCLES+3.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse. Holding a key produces one pulse only; release must also debounce before the next pulse.
- `alu_req` rises on the edge that enters ISSUE. It falls on the edge where ack is sampled (1-cycle minimum req). The result is captured on that same edge.
- Ack present in the first ISSUE cycle: SHOW is entered on the next edge.
- Timeout: with `ACK_TIMEOUT`=N, no ack within N cycles of ISSUE → SHOW on the N-th edge after entry.
- Clear during ISSUE: `alu_req` drops on the edge that acts on the clear.
- Asynchronous reset mid-handshake: `alu_req` is 0 immediately, with no glitch back to 1.

## Test plan
- Reset: assert reset at any time → `led`=8'h10, `alu_req`=0, `alu_a/b/op`=0 at once.
- Add with carry (DEBOUNCE_CYCLES=4): enter A=9, B=8, op=00; responder acks 2 cycles after req with result=1, carry=1, zero=0 → `alu_a`=9, `alu_b`=8, `alu_op`=00 stable throughout req; req high 3 cycles; `led`=8'h91.
- Chain: from the previous SHOW, press chain, enter B=1, op=01 → req with `alu_a`=1, `alu_b`=1, `alu_op`=01; ack with result=0, zero=1 → `led`=8'hA0.
- Debounce: enter glitches of 3 cycles (DEBOUNCE_CYCLES=4), repeated → state stays GET_A, `led`[6:4]=001. A 6-cycle hold → exactly one transition to GET_B.
- Timeout (ACK_TIMEOUT=8): no ack → SHOW 8 edges after ISSUE entry, `led`=8'hC0; a subsequent chain press is ignored; a late ack is ignored.
- Clear mid-ISSUE plus simultaneous pulses: clear while req=1 → req drops on the acting edge, `led`=8'h10 (data=0). Clear and enter pulsing in the same cycle in GET_B → GET_A, B not loaded.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects operand A, operand B and opcode from the
// board keys, issues them to the mini ALU over req/ack, and shows the result.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   key[7:0]                [3:0] data, [4] enter, [5] clear, [6] chain, [7] unused
//   alu_a/alu_b/alu_op      operands and opcode presented to the ALU (registered)
//   alu_req                 request to the ALU responder (registered)
//   alu_ack                 responder ack; alu_result/carry/zero valid with it
//   led[7:0]                status/result display, decoded from registers
module alu_operand_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT     = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] key,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    output logic       alu_req,
    input  logic       alu_ack,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic [7:0] led
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam bit TO_EN = (ACK_TIMEOUT != 0);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        ISSUE  = 3'd3,
        SHOW   = 3'd4
    } state_t;

    // key[7] carries no function
    logic key_unused;
    assign key_unused = key[7];

    // Two-flop synchronizer for data and control keys
    logic [6:0] sync_meta;
    logic [6:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= key[6:0];
            sync_q    <= sync_meta;
        end
    end

    logic [3:0] data;
    logic [2:0] ctl_sync;
    assign data     = sync_q[3:0];
    assign ctl_sync = sync_q[6:4];

    // Debounce enter/clear/chain: level flips after DEBOUNCE_CYCLES stable mismatches
    logic [2:0]      deb_q;
    logic [2:0]      deb_prev;
    logic [DB_W-1:0] deb_cnt [3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_q    <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_prev <= deb_q;
            for (int i = 0; i < 3; i++) begin
                if (ctl_sync[i] != deb_q[i]) begin
                    if (deb_cnt[i] == DB_LAST) begin
                        deb_q[i]   <= ctl_sync[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle pulse on each rising debounced level
    logic [2:0] pulse_c;
    logic       enter_c;
    logic       clear_c;
    logic       chain_c;
    assign pulse_c = deb_q & ~deb_prev;
    assign enter_c = pulse_c[0];
    assign clear_c = pulse_c[1];
    assign chain_c = pulse_c[2];

    // Sequencer FSM and result registers
    state_t          state;
    logic [3:0]      result;
    logic            carry;
    logic            zero;
    logic            error;
    logic            result_valid;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= GET_A;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_req      <= 1'b0;
            result       <= '0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            error        <= 1'b0;
            result_valid <= 1'b0;
            to_cnt       <= '0;
        end else if (clear_c) begin
            // Clear wins over every other pulse and aborts a pending request
            state        <= GET_A;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_req      <= 1'b0;
            result       <= '0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            error        <= 1'b0;
            result_valid <= 1'b0;
            to_cnt       <= '0;
        end else begin
            case (state)
                GET_A: begin
                    if (enter_c) begin
                        alu_a <= data;
                        state <= GET_B;
                    end else if (chain_c && result_valid) begin
                        alu_a <= result;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (enter_c) begin
                        alu_b <= data;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (enter_c) begin
                        alu_op  <= data[1:0];
                        alu_req <= 1'b1;
                        to_cnt  <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (alu_ack) begin
                        result       <= alu_result;
                        carry        <= alu_carry;
                        zero         <= alu_zero;
                        error        <= 1'b0;
                        result_valid <= 1'b1;
                        alu_req      <= 1'b0;
                        state        <= SHOW;
                    end else if (TO_EN && (to_cnt == TO_LAST)) begin
                        result       <= '0;
                        carry        <= 1'b0;
                        zero         <= 1'b0;
                        error        <= 1'b1;
                        result_valid <= 1'b0;
                        alu_req      <= 1'b0;
                        state        <= SHOW;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                SHOW: begin
                    // After a timeout result_valid is 0, so chain is ignored
                    if (enter_c) begin
                        state <= GET_A;
                    end else if (chain_c && result_valid) begin
                        alu_a <= result;
                        state <= GET_B;
                    end
                end
                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

    // LED decode from registered state
    always_comb begin
        led = 8'h00;
        case (state)
            GET_A:   led = {1'b0, 3'b001, data};
            GET_B:   led = {1'b0, 3'b010, data};
            GET_OP:  led = {1'b0, 3'b100, data};
            ISSUE:   led = 8'h80;
            SHOW:    led = {1'b1, error, zero, carry, result};
            default: led = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer: scoreboard of expected ALU transactions
// pushed when keys are entered and popped when the request appears.
module tb_alu_operand_sequencer;

    localparam int unsigned DB = 4;
    localparam int unsigned TO = 8;

    logic       clock;
    logic       reset;
    logic [7:0] key;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_req;
    logic       alu_ack;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic [7:0] led;

    alu_operand_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .ACK_TIMEOUT    (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key       (key),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_req   (alu_req),
        .alu_ack   (alu_ack),
        .alu_result(alu_result),
        .alu_carry (alu_carry),
        .alu_zero  (alu_zero),
        .led       (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ack_delay >= 0: ack that many cycles after req; -1: no ack (timeout)
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        int         ack_delay;
        logic [3:0] res;
        logic       carry;
        logic       zero;
        logic [7:0] exp_led;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [3:0] last_result;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Idle long enough for any earlier release to debounce, then press;
    // returns just after the edge on which the FSM acts on the pulse.
    task automatic press(input int idx);
        repeat (DB + 4) tick();
        key[idx] = 1'b1;
        repeat (DB + 3) tick();
        key[idx] = 1'b0;
    endtask

    task automatic enter_nibble(input logic [3:0] d);
        key[3:0] = d;
        press(4);
    endtask

    function automatic item_t mk_item(input logic [3:0] a, input logic [3:0] b,
                                      input logic [1:0] op, input int dly,
                                      input logic [3:0] res, input logic c,
                                      input logic z);
        item_t it;
        it.a = a;
        it.b = b;
        it.op = op;
        it.ack_delay = dly;
        it.res = res;
        it.carry = c;
        it.zero = z;
        if (dly >= 0) it.exp_led = {1'b1, 1'b0, z, c, res};
        else          it.exp_led = 8'hC0;
        return it;
    endfunction

    // Wait (bounded) for req, pop the expected item and play responder
    task automatic wait_req_pop(output item_t it, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (alu_req !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        check("req_rise", 32'(alu_req), 32'd1);
        check("sb_size", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            it = sb.pop_front();
            ok = 1'b1;
            check("req_abop", {alu_a, alu_b, alu_op}, {it.a, it.b, it.op});
            check("led_issue", 32'(led), 32'h80);
        end
    endtask

    task automatic run_item();
        item_t it;
        bit ok;
        int cnt;
        wait_req_pop(it, ok);
        if (ok) begin
            cnt = 0;
            if (it.ack_delay >= 0) begin
                for (int i = 0; i < it.ack_delay; i++) begin
                    if (alu_req === 1'b1) cnt++;
                    check("hold_abop", {alu_a, alu_b, alu_op}, {it.a, it.b, it.op});
                    tick();
                end
                if (alu_req === 1'b1) cnt++;
                alu_ack = 1'b1;
                alu_result = it.res;
                alu_carry = it.carry;
                alu_zero = it.zero;
                tick();
                alu_ack = 1'b0;
                alu_result = 4'h0;
                alu_carry = 1'b0;
                alu_zero = 1'b0;
                check("req_cycles", 32'(cnt), 32'(it.ack_delay + 1));
                last_result = it.res;
            end else begin
                while (alu_req === 1'b1 && cnt < 40) begin
                    check("hold_abop", {alu_a, alu_b, alu_op}, {it.a, it.b, it.op});
                    cnt++;
                    tick();
                end
                check("timeout_edges", 32'(cnt), 32'(TO));
            end
            check("req_fall", 32'(alu_req), 32'd0);
            check("led_show", 32'(led), 32'(it.exp_led));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t it;
        bit ok;
        reset = 1'b0;
        key = 8'h00;
        alu_ack = 1'b0;
        alu_result = 4'h0;
        alu_carry = 1'b0;
        alu_zero = 1'b0;
        last_result = 4'h0;

        // Reset values
        #2 reset = 1'b1;
        #1;
        check("rst_led", 32'(led), 32'h10);
        check("rst_req", 32'(alu_req), 32'd0);
        check("rst_abop", {alu_a, alu_b, alu_op}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Short glitches on enter produce no pulse
        key[3:0] = 4'h5;
        for (int g = 0; g < 4; g++) begin
            key[4] = 1'b1;
            repeat (3) tick();
            key[4] = 1'b0;
            repeat (3) tick();
        end
        repeat (10) tick();
        check("glitch_led", 32'(led), 32'h15);

        // A 6-cycle hold: FSM acts on edge DB+3, exactly once
        key[4] = 1'b1;
        repeat (6) tick();
        key[4] = 1'b0;
        check("pre_pulse", 32'(led[6:4]), 32'd1);
        tick();
        check("on_pulse", 32'(led[6:4]), 32'd2);
        repeat (20) tick();
        check("single_pulse", 32'(led[6:4]), 32'd2);

        // Clear back to GET_A, loaded A is dropped
        press(5);
        check("clr_led", 32'(led), 32'h15);
        check("clr_a", 32'(alu_a), 32'd0);

        // Add with carry; key[7] toggled to show it has no effect
        key[7] = 1'b1;
        enter_nibble(4'h9);
        check("st_getb", 32'(led[6:4]), 32'd2);
        enter_nibble(4'h8);
        check("st_getop", 32'(led[6:4]), 32'd4);
        sb.push_back(mk_item(4'h9, 4'h8, 2'b00, 2, 4'h1, 1'b1, 1'b0));
        enter_nibble(4'h0);
        run_item();
        check("add_led", 32'(led), 32'h91);
        key[7] = 1'b0;

        // Chain the previous result into A
        press(6);
        check("chain_getb", 32'(led[6:4]), 32'd2);
        check("chain_a", 32'(alu_a), 32'(last_result));
        enter_nibble(4'h1);
        sb.push_back(mk_item(last_result, 4'h1, 2'b01, 1, 4'h0, 1'b0, 1'b1));
        enter_nibble(4'h1);
        run_item();
        check("chain_led", 32'(led), 32'hA0);

        // Timeout, then chain and late ack both ignored
        press(4);
        check("show_to_geta", 32'(led[6:4]), 32'd1);
        enter_nibble(4'h3);
        enter_nibble(4'h4);
        sb.push_back(mk_item(4'h3, 4'h4, 2'b10, -1, 4'h0, 1'b0, 1'b0));
        enter_nibble(4'h2);
        run_item();
        press(6);
        check("to_chain_ign", 32'(led), 32'hC0);
        alu_ack = 1'b1;
        alu_result = 4'h7;
        alu_carry = 1'b1;
        repeat (2) tick();
        alu_ack = 1'b0;
        alu_result = 4'h0;
        alu_carry = 1'b0;
        tick();
        check("late_ack_led", 32'(led), 32'hC0);
        check("late_ack_req", 32'(alu_req), 32'd0);

        // Clear while req is high: req drops on the acting edge
        press(4);
        enter_nibble(4'h2);
        enter_nibble(4'h3);
        sb.push_back(mk_item(4'h2, 4'h3, 2'b01, -1, 4'h0, 1'b0, 1'b0));
        repeat (DB + 4) tick();
        key[3:0] = 4'h1;
        key[4] = 1'b1;
        repeat (3) tick();
        key[5] = 1'b1;
        repeat (4) tick();
        key[4] = 1'b0;
        key[3:0] = 4'h0;
        wait_req_pop(it, ok);
        repeat (2) tick();
        check("clr_req_hold", 32'(alu_req), 32'd1);
        tick();
        check("clr_req_drop", 32'(alu_req), 32'd0);
        check("clr_issue_led", 32'(led), 32'h10);
        check("clr_abop", {alu_a, alu_b, alu_op}, 32'd0);
        key[5] = 1'b0;

        // Clear and enter pulsing together in GET_B: clear wins
        enter_nibble(4'h6);
        check("pair_getb", 32'(led[6:4]), 32'd2);
        repeat (DB + 4) tick();
        key[3:0] = 4'h9;
        key[4] = 1'b1;
        key[5] = 1'b1;
        repeat (DB + 3) tick();
        key[4] = 1'b0;
        key[5] = 1'b0;
        check("pair_geta", 32'(led[6:4]), 32'd1);
        check("pair_ab", {alu_a, alu_b}, 32'd0);

        // Asynchronous reset during a pending request
        enter_nibble(4'h5);
        enter_nibble(4'h6);
        sb.push_back(mk_item(4'h5, 4'h6, 2'b11, -1, 4'h0, 1'b0, 1'b0));
        enter_nibble(4'h3);
        wait_req_pop(it, ok);
        tick();
        #3 reset = 1'b1;
        #1;
        check("arst_req", 32'(alu_req), 32'd0);
        check("arst_abop", {alu_a, alu_b, alu_op}, 32'd0);
        repeat (2) tick();
        check("arst_req_hold", 32'(alu_req), 32'd0);
        key[3:0] = 4'h0;
        reset = 1'b0;
        repeat (3) tick();
        check("arst_led", 32'(led), 32'h10);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
